// File: rtl/fwd_hazard_ctrl_if.sv
// Bundles the ID-stage hazard inputs and the forwarding/stall outputs of
// fwd_hazard_ctrl; master = pipeline decode side, slave = hazard unit.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic                  stall;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output id_rd, id_reg_write, id_mem_read, flush,
        input  stall, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  id_rd, id_reg_write, id_mem_read, flush,
        output stall, fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generator with load-use stall detection.
// Optional macro FWD_LOAD_DATA_PATH_EN: MEM-stage load matches select code 11.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    fwd_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        SEL_RF   = 2'b00,
        SEL_EX   = 2'b01,
        SEL_MEM  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    // WB needs no shadow: the register file is write-through, so a WB-stage
    // producer is already visible to the ID read and never forwarded.
    stage_t ex_q;
    stage_t mem_q;
    stage_t id_stage;

    sel_e             sel_a_q;
    sel_e             sel_b_q;
    sel_e             sel_a_d;
    sel_e             sel_b_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall_c;
    logic             bubble_c;
    logic             advance_c;

    function automatic logic hits(
        input stage_t                s,
        input logic                  used,
        input logic [REG_ADDR_W-1:0] rs
    );
        return used && s.valid && s.reg_write && (s.rd != '0) && (s.rd == rs);
    endfunction

    function automatic sel_e pick(
        input stage_t                ex,
        input stage_t                mem,
        input logic                  used,
        input logic [REG_ADDR_W-1:0] rs
    );
        sel_e r;
        r = SEL_RF;
        if (hits(ex, used, rs)) begin
            r = SEL_EX;
        end else if (hits(mem, used, rs)) begin
`ifdef FWD_LOAD_DATA_PATH_EN
            r = mem.mem_read ? SEL_LOAD : SEL_MEM;
`else
            r = SEL_MEM;
`endif
        end
        return r;
    endfunction

    always_comb begin
        id_stage.valid     = 1'b1;
        id_stage.rd        = bus.id_rd;
        id_stage.reg_write = bus.id_reg_write;
        id_stage.mem_read  = bus.id_mem_read;

        // Gated by rst so stall drops the instant reset is raised, even
        // before the async clear has propagated through ex_q.
        stall_c = !rst && bus.id_valid && !bus.flush && ex_q.mem_read &&
                  (hits(ex_q, bus.id_uses_rs1, bus.id_rs1) ||
                   hits(ex_q, bus.id_uses_rs2, bus.id_rs2));

        bubble_c  = !bus.id_valid || stall_c || bus.flush;
        advance_c = !bubble_c;

        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (!bubble_c) begin
            sel_a_d = pick(ex_q, mem_q, bus.id_uses_rs1, bus.id_rs1);
            sel_b_d = pick(ex_q, mem_q, bus.id_uses_rs2, bus.id_rs2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
            stall_cnt_q <= '0;
        end else begin
            mem_q   <= ex_q;
            ex_q    <= advance_c ? id_stage : '0;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall     = stall_c;
    assign bus.fwd_a_sel = sel_a_q;
    assign bus.fwd_b_sel = sel_b_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
